// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

   // Operation encoding, identical to funct3[1:0] of DIV/DIVU/REM/REMU
   typedef enum logic [1:0] {
      DIV_OP  = 2'b00,
      DIVU_OP = 2'b01,
      REM_OP  = 2'b10,
      REMU_OP = 2'b11
   } div_op_t;

   // Control states of the divider sequencer
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_DIVIDE = 2'b01,
      ST_FIXUP  = 2'b10,
      ST_DONE   = 2'b11
   } div_state_t;

   localparam int          DIV_ITERATIONS       = 32;
   localparam logic [31:0] DIV_BY_ZERO_QUOTIENT = 32'hFFFFFFFF;

   // Two's complement negation when neg is set, pass-through otherwise
   function automatic logic [31:0] cond_negate(input logic [31:0] value, input logic neg);
      logic [31:0] res;
      if (neg) begin
         res = ~value + 32'd1;
      end else begin
         res = value;
      end
      return res;
   endfunction

endpackage

// File: rtl/div_unsigned_core.sv
// Unsigned restoring radix-2 datapath: 32 iterations, one quotient bit each.
// The dividend is shifted out of the quotient register MSB-first while the
// quotient bits are shifted in at the bottom.
module div_unsigned_core
   import div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        finished,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   localparam logic [4:0] LAST_COUNT = 5'(DIV_ITERATIONS - 1);

   logic [31:0] rem_r;
   logic [31:0] quo_r;
   logic [31:0] dvs_r;
   logic [4:0]  count_r;
   logic        busy_r;
   logic [32:0] shifted_s;
   logic [32:0] diff_s;

   // Trial subtraction of the divisor from the shifted 33-bit partial remainder
   always_comb begin
      shifted_s = {rem_r, quo_r[31]};
      diff_s    = shifted_s - {1'b0, dvs_r};
   end

   // Iteration registers: load on start, then restore-or-keep each busy cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_r   <= 32'd0;
         quo_r   <= 32'd0;
         dvs_r   <= 32'd0;
         count_r <= 5'd0;
         busy_r  <= 1'b0;
      end else if (start) begin
         rem_r   <= 32'd0;
         quo_r   <= dividend;
         dvs_r   <= divisor;
         count_r <= 5'd0;
         busy_r  <= 1'b1;
      end else if (busy_r) begin
         if (diff_s[32]) begin
            rem_r <= shifted_s[31:0];
            quo_r <= {quo_r[30:0], 1'b0};
         end else begin
            rem_r <= diff_s[31:0];
            quo_r <= {quo_r[30:0], 1'b1};
         end
         count_r <= count_r + 5'd1;
         busy_r  <= (count_r != LAST_COUNT);
      end
   end

   // The last iteration is in progress; results are final on the next cycle
   assign finished  = busy_r & (count_r == LAST_COUNT);
   assign quotient  = quo_r;
   assign remainder = rem_r;

endmodule

// File: rtl/div.sv
// Iterative 32-bit divider for DIV/DIVU/REM/REMU, one operation in flight.
// Accept at cycle N gives done at N+34. Optional macro DIV_EARLY_EXIT_EN
// lets divide-by-zero and |A|<|B| bypass the iterations (done at N+2).
module div
   import div_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            new_request,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            ready,
   output logic            done,
   output logic [1:0]      completed_op,
   output logic [XLEN-1:0] result
);

   generate
      if (XLEN != 32) begin : g_xlen_check
         $error("div: only XLEN=32 is supported");
      end
   endgenerate

   div_state_t  state_r;
   div_op_t     op_r;
   logic [31:0] a_r;
   logic        neg_a_r;
   logic        neg_b_r;
   logic        zero_r;
   logic        bypass_r;

   logic        accept_s;
   logic        neg_a_s;
   logic        neg_b_s;
   logic        zero_s;
   logic        early_s;
   logic        start_s;
   logic [31:0] mag_a_s;
   logic [31:0] mag_b_s;
   logic        core_finished_s;
   logic [31:0] core_q_s;
   logic [31:0] core_r_s;
   logic [31:0] quot_s;
   logic [31:0] rem_s;
   logic [31:0] fix_result_s;

   // Accept decode and operand magnitudes for the unsigned core
   always_comb begin
      accept_s = new_request & ready;
      neg_a_s  = A[31] & ~op[0];
      neg_b_s  = B[31] & ~op[0];
      mag_a_s  = cond_negate(A, neg_a_s);
      mag_b_s  = cond_negate(B, neg_b_s);
      zero_s   = (B == 32'd0);
`ifdef DIV_EARLY_EXIT_EN
      early_s  = zero_s | (mag_a_s < mag_b_s);
`else
      early_s  = 1'b0;
`endif
      start_s  = accept_s & ~early_s;
   end

   div_unsigned_core u_core (
      .clk       (clk),
      .rst       (rst),
      .start     (start_s),
      .dividend  (mag_a_s),
      .divisor   (mag_b_s),
      .finished  (core_finished_s),
      .quotient  (core_q_s),
      .remainder (core_r_s)
   );

   // Sign restoration, special-case overrides and quotient/remainder select
   always_comb begin
      if (zero_r) begin
         quot_s = DIV_BY_ZERO_QUOTIENT;
         rem_s  = a_r;
      end else if (bypass_r) begin
         quot_s = 32'd0;
         rem_s  = a_r;
      end else begin
         quot_s = cond_negate(core_q_s, neg_a_r ^ neg_b_r);
         rem_s  = cond_negate(core_r_s, neg_a_r);
      end
      fix_result_s = op_r[1] ? rem_s : quot_s;
   end

   // Sequencer with operand capture and registered handshake/result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         ready        <= 1'b1;
         done         <= 1'b0;
         completed_op <= 2'b00;
         result       <= 32'd0;
         op_r         <= DIV_OP;
         a_r          <= 32'd0;
         neg_a_r      <= 1'b0;
         neg_b_r      <= 1'b0;
         zero_r       <= 1'b0;
         bypass_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (accept_s) begin
                  op_r     <= div_op_t'(op);
                  a_r      <= A;
                  neg_a_r  <= neg_a_s;
                  neg_b_r  <= neg_b_s;
                  zero_r   <= zero_s;
                  bypass_r <= early_s & ~zero_s;
                  ready    <= 1'b0;
                  state_r  <= early_s ? ST_FIXUP : ST_DIVIDE;
               end else begin
                  ready   <= 1'b1;
                  state_r <= ST_IDLE;
               end
            end
            ST_DIVIDE: begin
               if (core_finished_s) begin
                  state_r <= ST_FIXUP;
               end else begin
                  state_r <= ST_DIVIDE;
               end
            end
            ST_FIXUP: begin
               result       <= fix_result_s;
               completed_op <= op_r;
               done         <= 1'b1;
               ready        <= 1'b1;
               state_r      <= ST_DONE;
            end
            default: begin
               state_r <= ST_IDLE;
               ready   <= 1'b1;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: stimulus pushes expected results, a monitor
// pops and compares on every done pulse (value, op and completion cycle).
module tb_div;
   import div_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        new_request;
   logic [1:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        ready;
   logic        done;
   logic [1:0]  completed_op;
   logic [31:0] result;

   div #(.XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .new_request  (new_request),
      .op           (op),
      .A            (A),
      .B            (B),
      .ready        (ready),
      .done         (done),
      .completed_op (completed_op),
      .result       (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] res;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   // Signed or unsigned magnitude of an operand as a wide integer
   function automatic longint mag(input logic [31:0] v, input logic sgn);
      longint sv;
      sv = sgn ? longint'($signed(v)) : longint'({32'd0, v});
      return (sv < 0) ? -sv : sv;
   endfunction

   // Reference: RISC-V division semantics from plain arithmetic
   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint x, y, q, r;
      if (b == 32'd0) return o[1] ? a : 32'hFFFFFFFF;
      x = o[0] ? longint'({32'd0, a}) : longint'($signed(a));
      y = o[0] ? longint'({32'd0, b}) : longint'($signed(b));
      q = x / y;
      r = x % y;
      return o[1] ? r[31:0] : q[31:0];
   endfunction

   function automatic int latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_EXIT_EN
      if (b == 32'd0 || mag(a, ~o[0]) < mag(b, ~o[0])) return 2;
`endif
      return 34;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFFFFFF;
         3:       return 32'h80000000;
         4:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Wait for ready (bounded), present one request, push its expectation
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
      exp_t e;
      int w = 0;
      while (!ready && w < 100) begin
         tick();
         w++;
      end
      check("ready_wait", {31'd0, ready}, 32'd1);
      if (ready) begin
         new_request = 1'b1;
         op = o; A = a; B = b;
         e.op = o; e.res = expv; e.due = cyc + latency(o, a, b);
         exp_q.push_back(e);
         tick();
         new_request = 1'b0;
         op = 2'($urandom); A = $urandom; B = $urandom;
      end
   endtask

   // Cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: compare every done pulse against the scoreboard head
   initial begin
      exp_t e;
      logic prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_done = 1'b0;
         end else begin
            if (done) begin
               check("done_single_pulse", {31'd0, prev_done}, 32'd0);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_done: got done=1 result=%h required no done", result);
               end else begin
                  e = exp_q.pop_front();
                  check("result", result, e.res);
                  check("completed_op", {30'd0, completed_op}, {30'd0, e.op});
                  check("done_cycle", 32'(cyc), 32'(e.due));
               end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
               n_checks++;
               n_errors++;
               $display("FAIL done_timeout: got no done by cycle %0d required done at %0d", cyc, exp_q[0].due);
               e = exp_q.pop_front();
            end
            prev_done = done;
         end
      end
   end

   initial begin
      logic [1:0]  o;
      logic [31:0] a, b;
      int w;
      rst = 1'b1; new_request = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0;
      repeat (3) tick();
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_completed_op", {30'd0, completed_op}, 32'd0);
      check("rst_result", result, 32'd0);
      rst = 1'b0;
      tick();

      // Directed cases with hand-derived values
      issue(DIV_OP,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
      issue(REM_OP,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
      issue(REMU_OP, 32'd7, 32'd2, 32'd1);
      issue(DIVU_OP, 32'd5, 32'd0, 32'hFFFFFFFF);
      issue(REM_OP,  32'd5, 32'd0, 32'd5);
      issue(DIV_OP,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      issue(REM_OP,  32'h80000000, 32'hFFFFFFFF, 32'd0);

      // Request while busy must be ignored
      issue(DIVU_OP, 32'd1000, 32'd3, 32'd333);
      repeat (5) tick();
      check("busy_ready", {31'd0, ready}, 32'd0);
      new_request = 1'b1; op = REMU_OP; A = 32'd9; B = 32'd4;
      tick();
      new_request = 1'b0;

      // Reset in the middle of an operation (count 15)
      issue(DIVU_OP, 32'd50000, 32'd7, 32'd7142);
      repeat (15) tick();
      rst = 1'b1;
      exp_q.delete();
      tick();
      rst = 1'b0;
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_result", result, 32'd0);
      repeat (40) tick();
      issue(DIVU_OP, 32'd100, 32'd7, 32'd14);

      // Randomized traffic, mostly back-to-back, sometimes from idle
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = pick();
         b = pick();
         issue(o, a, b, model(o, a, b));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(30, 40)) tick();
      end

      w = 0;
      while (exp_q.size() > 0 && w < 200) begin
         tick();
         w++;
      end
      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
